// File: rtl/producer_multi.sv
// producer_multi -- N-channel strided burst producer.
//
// Each channel runs its own two-state FSM (IDLE/RUN). A start pulse in IDLE
// loads the base address and beat count; while in RUN one beat is accepted
// per cycle unless that channel is stalled. The transaction ID is never
// reloaded: it increments on every accepted beat across bursts and wraps.
//
// Optional feature macro: PRODUCER_STALL_CNT_EN
//   defined   -> per-channel saturating 16-bit stall-cycle counter
//   undefined -> out_stall_count tied to 0 (port still present)
//
// Ports (channel c uses slice [c*W +: W] of each flattened bus):
//   clk             in   clock, posedge
//   reset           in   synchronous active-high reset
//   in_start        in   [NUM_CH]                 start pulse
//   in_base         in   [NUM_CH*ADDRESS_WIDTH]   burst base, sampled with start
//   in_length       in   [NUM_CH*LEN_WIDTH]       beat count, sampled with start
//   in_stall        in   [NUM_CH]                 backpressure
//   out_address     out  [NUM_CH*ADDRESS_WIDTH]   address of current beat
//   out_id          out  [NUM_CH*ID_WIDTH]        ID of current beat
//   out_valid       out  [NUM_CH]                 beat presented and accepted
//   out_busy        out  [NUM_CH]                 channel FSM is in RUN
//   out_done        out  [NUM_CH]                 one-cycle burst-complete pulse
//   out_stall_count out  [NUM_CH*16]              stall cycles of current/last burst
//
// Handshake: there is no separate ready. In RUN, out_valid = !in_stall and a
// beat is consumed in exactly the cycles where out_valid is high; the stall
// input acts as the inverted ready of the downstream stall pipeline, so this
// path is combinational from in_stall to out_valid.
// out_busy is the per-channel FSM state bit and can be used to observe it.

module producer_multi #(
  parameter int NUM_CH        = 2,
  parameter int ADDRESS_WIDTH = 32,
  parameter int ID_WIDTH      = 8,
  parameter int LEN_WIDTH     = 16,
  parameter int STRIDE        = 4
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [NUM_CH-1:0]               in_start,
  input  logic [NUM_CH*ADDRESS_WIDTH-1:0] in_base,
  input  logic [NUM_CH*LEN_WIDTH-1:0]     in_length,
  input  logic [NUM_CH-1:0]               in_stall,
  output logic [NUM_CH*ADDRESS_WIDTH-1:0] out_address,
  output logic [NUM_CH*ID_WIDTH-1:0]      out_id,
  output logic [NUM_CH-1:0]               out_valid,
  output logic [NUM_CH-1:0]               out_busy,
  output logic [NUM_CH-1:0]               out_done,
  output logic [NUM_CH*16-1:0]            out_stall_count
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    state_e                   state_q, state_d;
    logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
    logic [ID_WIDTH-1:0]      id_q, id_d;
    logic [LEN_WIDTH-1:0]     rem_q, rem_d;
    logic                     done_q, done_d;
    logic                     accept;
    logic                     start_ok;

    // A start only counts when the channel is idle; starts in RUN are dropped.
    assign start_ok = (state_q == ST_IDLE) && in_start[c];

    always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      id_d    = id_q;
      rem_d   = rem_q;
      done_d  = 1'b0;
      accept  = 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (in_start[c]) begin
            if (in_length[c*LEN_WIDTH +: LEN_WIDTH] != '0) begin
              state_d = ST_RUN;
              addr_d  = in_base[c*ADDRESS_WIDTH +: ADDRESS_WIDTH];
              rem_d   = in_length[c*LEN_WIDTH +: LEN_WIDTH];
            end else begin
              // Empty burst: report completion without issuing beats.
              done_d = 1'b1;
            end
          end
        end
        ST_RUN: begin
          if (!in_stall[c]) begin
            accept = 1'b1;
            addr_d = addr_q + ADDRESS_WIDTH'(STRIDE);
            id_d   = id_q + ID_WIDTH'(1);
            rem_d  = rem_q - LEN_WIDTH'(1);
            if (rem_q == LEN_WIDTH'(1)) begin
              state_d = ST_IDLE;
              done_d  = 1'b1;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        state_q <= ST_IDLE;
        addr_q  <= '0;
        id_q    <= '0;
        rem_q   <= '0;
        done_q  <= 1'b0;
      end else begin
        state_q <= state_d;
        addr_q  <= addr_d;
        id_q    <= id_d;
        rem_q   <= rem_d;
        done_q  <= done_d;
      end
    end

    assign out_address[c*ADDRESS_WIDTH +: ADDRESS_WIDTH] = addr_q;
    assign out_id[c*ID_WIDTH +: ID_WIDTH]                = id_q;
    assign out_valid[c]                                  = accept;
    assign out_busy[c]                                   = (state_q == ST_RUN);
    assign out_done[c]                                   = done_q;

`ifdef PRODUCER_STALL_CNT_EN
    logic [15:0] scnt_q, scnt_d;

    // Cleared by any accepted start (length 0 included), counts stalled RUN
    // cycles, saturates at all-ones, holds while idle.
    always_comb begin
      scnt_d = scnt_q;
      if (start_ok) begin
        scnt_d = '0;
      end else if ((state_q == ST_RUN) && in_stall[c] && (scnt_q != 16'hFFFF)) begin
        scnt_d = scnt_q + 16'd1;
      end
    end

    always_ff @(posedge clk) begin
      if (reset) scnt_q <= '0;
      else       scnt_q <= scnt_d;
    end

    assign out_stall_count[c*16 +: 16] = scnt_q;
`else
    logic unused_start_ok;
    assign unused_start_ok             = start_ok;
    assign out_stall_count[c*16 +: 16] = 16'h0000;
`endif
  end

endmodule

// File: tb/tb_producer_multi.sv
module tb_producer_multi;

  localparam int NCH = 4;
  localparam int AW  = 32;
  localparam int IW  = 8;
  localparam int LW  = 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // ---------------- main DUT (4 channels) ----------------
  logic [NCH-1:0]    in_start, in_stall;
  logic [NCH*AW-1:0] in_base;
  logic [NCH*LW-1:0] in_length;
  logic [NCH*AW-1:0] out_address;
  logic [NCH*IW-1:0] out_id;
  logic [NCH-1:0]    out_valid, out_busy, out_done;
  logic [NCH*16-1:0] out_stall_count;

  producer_multi #(.NUM_CH(NCH), .ADDRESS_WIDTH(AW), .ID_WIDTH(IW),
                   .LEN_WIDTH(LW), .STRIDE(4)) u_dut (
    .clk(clk), .reset(reset),
    .in_start(in_start), .in_base(in_base), .in_length(in_length),
    .in_stall(in_stall),
    .out_address(out_address), .out_id(out_id), .out_valid(out_valid),
    .out_busy(out_busy), .out_done(out_done),
    .out_stall_count(out_stall_count)
  );

  // ---------------- wrap DUT (1 channel, narrow) ----------------
  logic [0:0]  w_start, w_stall, w_valid, w_busy, w_done;
  logic [7:0]  w_base, w_length, w_address;
  logic [1:0]  w_id;
  logic [15:0] w_scnt;

  producer_multi #(.NUM_CH(1), .ADDRESS_WIDTH(8), .ID_WIDTH(2),
                   .LEN_WIDTH(8), .STRIDE(4)) u_wrap (
    .clk(clk), .reset(reset),
    .in_start(w_start), .in_base(w_base), .in_length(w_length),
    .in_stall(w_stall),
    .out_address(w_address), .out_id(w_id), .out_valid(w_valid),
    .out_busy(w_busy), .out_done(w_done),
    .out_stall_count(w_scnt)
  );

  // ---------------- scoreboard counters ----------------
  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    in_start  = '0;
    in_stall  = '0;
    in_base   = '0;
    in_length = '0;
    w_start   = '0;
    w_stall   = '0;
    w_base    = '0;
    w_length  = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic drive_ch0(input logic st, input logic [31:0] base,
                           input logic [15:0] len, input logic stl);
    in_start       = '0;
    in_stall       = '0;
    in_base        = '0;
    in_length      = '0;
    in_start[0]    = st;
    in_stall[0]    = stl;
    in_base[31:0]  = base;
    in_length[15:0] = len;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_busy"},  64'(out_busy),  64'd0);
    check({tag, "_valid"}, 64'(out_valid), 64'd0);
    check({tag, "_done"},  64'(out_done),  64'd0);
    check({tag, "_addr"},  64'(out_address[63:0]), 64'd0);
    check({tag, "_addr_hi"}, 64'(out_address[127:64]), 64'd0);
    check({tag, "_id"},    64'(out_id),    64'd0);
    check({tag, "_scnt"},  64'(out_stall_count), 64'd0);
  endtask

  // ---------------- directed vector table (channel 0) ----------------
  typedef struct {
    logic        start;
    logic [31:0] base;
    logic [15:0] len;
    logic        stall;
    logic        valid;
    logic [31:0] addr;
    logic [7:0]  id;
    logic        busy;
    logic        done;
    logic [15:0] scnt;   // value when the stall counter is built
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic st, logic [31:0] b, logic [15:0] l, logic sl,
                              logic v, logic [31:0] a, logic [7:0] i,
                              logic bu, logic d, logic [15:0] sc);
    vec_t r;
    r.start = st; r.base = b; r.len = l; r.stall = sl;
    r.valid = v; r.addr = a; r.id = i; r.busy = bu; r.done = d; r.scnt = sc;
    return r;
  endfunction

  // independence test state
  logic [31:0] exp_q [NCH][$];
  int          exp_id [NCH];
  int          done_due [NCH];
  int          lens [NCH];

  logic [7:0] w_exp_addr [6];
  logic [1:0] w_exp_id   [6];

  initial begin
    // single burst, no stall
    vecs.push_back(mk(1, 32'h100, 3, 0,  0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0,        1, 32'h100, 0, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0,        1, 32'h104, 1, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0,        1, 32'h108, 2, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0,        0, 0, 0, 0, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0,        0, 0, 0, 0, 0, 0));
    // stall held two cycles after the first beat
    vecs.push_back(mk(1, 32'h200, 4, 0,  0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0,        1, 32'h200, 3, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1,        0, 0, 0, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1,        0, 0, 0, 1, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0,        1, 32'h204, 4, 1, 0, 2));
    vecs.push_back(mk(0, 0, 0, 0,        1, 32'h208, 5, 1, 0, 2));
    vecs.push_back(mk(0, 0, 0, 0,        1, 32'h20C, 6, 1, 0, 2));
    vecs.push_back(mk(0, 0, 0, 0,        0, 0, 0, 0, 1, 2));
    // stall while idle: no beat, counter holds
    vecs.push_back(mk(0, 0, 0, 1,        0, 0, 0, 0, 0, 2));
    // length-0 start clears counter and pulses done
    vecs.push_back(mk(1, 32'h777, 0, 0,  0, 0, 0, 0, 0, 2));
    vecs.push_back(mk(0, 0, 0, 0,        0, 0, 0, 0, 1, 0));
    vecs.push_back(mk(0, 0, 0, 1,        0, 0, 0, 0, 0, 0));
    // start while busy is ignored
    vecs.push_back(mk(1, 32'h300, 2, 0,  0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 32'h999, 5, 0,  1, 32'h300, 7, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0,        1, 32'h304, 8, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0,        0, 0, 0, 0, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0,        0, 0, 0, 0, 0, 0));

    w_exp_addr = '{8'hF8, 8'hFC, 8'h00, 8'h04, 8'h08, 8'h0C};
    w_exp_id   = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    lens       = '{3, 5, 2, 4};

    // ---------- reset state ----------
    do_reset();
    @(negedge clk);
    check_reset_values("reset");
    check("reset_wrap_busy", 64'(w_busy), 64'd0);
    check("reset_wrap_addr", 64'(w_address), 64'd0);
    next_cycle();

    // ---------- table-driven channel-0 sequence ----------
    foreach (vecs[i]) begin
      logic [15:0] sc_exp;
`ifdef PRODUCER_STALL_CNT_EN
      sc_exp = vecs[i].scnt;
`else
      sc_exp = 16'd0;
`endif
      drive_ch0(vecs[i].start, vecs[i].base, vecs[i].len, vecs[i].stall);
      @(negedge clk);
      check($sformatf("vec%0d_valid", i), 64'(out_valid[0]), 64'(vecs[i].valid));
      check($sformatf("vec%0d_busy", i),  64'(out_busy[0]),  64'(vecs[i].busy));
      check($sformatf("vec%0d_done", i),  64'(out_done[0]),  64'(vecs[i].done));
      check($sformatf("vec%0d_scnt", i),  64'(out_stall_count[15:0]), 64'(sc_exp));
      check($sformatf("vec%0d_others_busy", i), 64'(out_busy[3:1]), 64'd0);
      if (vecs[i].valid) begin
        check($sformatf("vec%0d_addr", i), 64'(out_address[31:0]), 64'(vecs[i].addr));
        check($sformatf("vec%0d_id", i),   64'(out_id[7:0]),        64'(vecs[i].id));
      end
      next_cycle();
    end
    drive_ch0(0, 0, 0, 0);

    // ---------- address / ID wrap on the narrow instance ----------
    w_start = 1'b1; w_base = 8'hF8; w_length = 8'd6;
    @(negedge clk);
    check("wrap_c0_busy", 64'(w_busy), 64'd0);
    next_cycle();
    w_start = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check($sformatf("wrap_b%0d_valid", k), 64'(w_valid), 64'd1);
      check($sformatf("wrap_b%0d_addr", k),  64'(w_address), 64'(w_exp_addr[k]));
      check($sformatf("wrap_b%0d_id", k),    64'(w_id), 64'(w_exp_id[k]));
      check($sformatf("wrap_b%0d_done", k),  64'(w_done), 64'd0);
      next_cycle();
    end
    @(negedge clk);
    check("wrap_end_done", 64'(w_done), 64'd1);
    check("wrap_end_busy", 64'(w_busy), 64'd0);
    check("wrap_end_valid", 64'(w_valid), 64'd0);
    next_cycle();

    // ---------- reset in the middle of a 5-beat burst ----------
    drive_ch0(1, 32'h500, 5, 0);
    next_cycle();
    drive_ch0(0, 0, 0, 0);
    @(negedge clk);
    check("rst_b0_valid", 64'(out_valid[0]), 64'd1);
    check("rst_b0_addr", 64'(out_address[31:0]), 64'h500);
    next_cycle();
    @(negedge clk);
    check("rst_b1_addr", 64'(out_address[31:0]), 64'h504);
    next_cycle();
    reset = 1'b1;            // asserted after the 2nd beat was accepted
    next_cycle();
    reset = 1'b0;
    @(negedge clk);
    check_reset_values("midrst");
    for (int k = 0; k < 4; k++) begin
      next_cycle();
      @(negedge clk);
      check($sformatf("midrst_nodone%0d", k), 64'(out_done[0]), 64'd0);
      check($sformatf("midrst_idle%0d", k),   64'(out_busy[0]), 64'd0);
    end
    next_cycle();
    drive_ch0(1, 32'h600, 1, 0);
    next_cycle();
    drive_ch0(0, 0, 0, 0);
    @(negedge clk);
    check("post_rst_valid", 64'(out_valid[0]), 64'd1);
    check("post_rst_addr", 64'(out_address[31:0]), 64'h600);
    check("post_rst_id", 64'(out_id[7:0]), 64'd0);
    next_cycle();
    @(negedge clk);
    check("post_rst_done", 64'(out_done[0]), 64'd1);
    check("post_rst_busy", 64'(out_busy[0]), 64'd0);
    next_cycle();

    // ---------- all channels together, independent stall patterns ----------
    do_reset();
    for (int c = 0; c < NCH; c++) begin
      exp_q[c].delete();
      for (int b = 0; b < lens[c]; b++)
        exp_q[c].push_back(32'h1000 * (c + 1) + 32'(4 * b));
      exp_id[c]   = 0;
      done_due[c] = -1;
      in_base[c*AW +: AW]   = 32'h1000 * (c + 1);
      in_length[c*LW +: LW] = 16'(lens[c]);
    end
    in_start = '1;
    in_stall = '0;
    @(negedge clk);
    check("ind_c0_busy", 64'(out_busy), 64'd0);
    next_cycle();
    in_start = '0;
    for (int cyc = 1; cyc <= 24; cyc++) begin
      for (int c = 0; c < NCH; c++)
        in_stall[c] = ((cyc % (c + 2)) == 1);
      @(negedge clk);
      for (int c = 0; c < NCH; c++) begin
        logic busy_exp;
        busy_exp = (exp_q[c].size() != 0);
        check($sformatf("ind_ch%0d_cyc%0d_busy", c, cyc), 64'(out_busy[c]), 64'(busy_exp));
        check($sformatf("ind_ch%0d_cyc%0d_valid", c, cyc), 64'(out_valid[c]),
              64'(busy_exp && !in_stall[c]));
        if (out_valid[c] && exp_q[c].size() != 0) begin
          logic [31:0] a;
          a = exp_q[c].pop_front();
          check($sformatf("ind_ch%0d_cyc%0d_addr", c, cyc), 64'(out_address[c*AW +: AW]), 64'(a));
          check($sformatf("ind_ch%0d_cyc%0d_id", c, cyc), 64'(out_id[c*IW +: IW]), 64'(exp_id[c]));
          exp_id[c]++;
          if (exp_q[c].size() == 0) done_due[c] = cyc + 1;
        end
        check($sformatf("ind_ch%0d_cyc%0d_done", c, cyc), 64'(out_done[c]),
              64'(cyc == done_due[c]));
      end
      next_cycle();
    end
    for (int c = 0; c < NCH; c++)
      check($sformatf("ind_ch%0d_beats_left", c), 64'(exp_q[c].size()), 64'd0);
    in_stall = '0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/producer_multi.md
# producer_multi

Parametrised N-channel transaction producer, the next generation of the dual-channel producer that feeds the stall-pipelined consumer path. Each channel runs a software-started burst of a programmed length. Every beat carries a strided address and a free-running transaction ID. Per-channel stall backpressure gates issue; a done pulse reports burst completion.

## Interface
Parameters:
- NUM_CH, 2: number of independent channels (1..16)
- ADDRESS_WIDTH, 32: address bits per channel
- ID_WIDTH, 8: ID bits per channel
- LEN_WIDTH, 16: burst length bits per channel
- STRIDE, 4: address increment per accepted beat

Ports (channel c occupies slice [c*W +: W] of each flattened bus):
- clk  in  1  clock; all logic on posedge
- reset  in  1  synchronous, active-high reset
- in_start  in  NUM_CH  per-channel start pulse
- in_base  in  NUM_CH*ADDRESS_WIDTH  burst start address, sampled with start
- in_length  in  NUM_CH*LEN_WIDTH  beats in burst, sampled with start
- in_stall  in  NUM_CH  per-channel backpressure
- out_address  out  NUM_CH*ADDRESS_WIDTH  address of current beat
- out_id  out  NUM_CH*ID_WIDTH  ID of current beat
- out_valid  out  NUM_CH  beat presented and accepted this cycle
- out_busy  out  NUM_CH  channel in RUN
- out_done  out  NUM_CH  one-cycle burst-complete pulse
- out_stall_count  out  NUM_CH*16  stall cycles in current/last burst (see Configuration)

## Operation
- Per-channel FSM, two states: IDLE, RUN. Channels are fully independent.
- IDLE, in_start[c]=1, in_length≠0: load address←in_base, remaining←in_length; go to RUN.
- IDLE, in_start[c]=1, in_length=0: stay IDLE; pulse out_done[c] next cycle; no beats issued.
- RUN: out_valid[c] = !in_stall[c]. This is a combinational path from in_stall, matching the existing stall pipeline. A beat is accepted in every RUN cycle with in_stall[c]=0.
- On an accepted beat:
  - address ← (address + STRIDE) mod 2^ADDRESS_WIDTH.
  - id ← (id + 1) mod 2^ID_WIDTH.
  - remaining ← remaining − 1.
- When remaining=1 and a beat is accepted: go to IDLE and pulse out_done[c] the following cycle.
- The ID is not reloaded by start; it runs continuously across bursts and wraps freely.
- The address restarts at in_base on each start and wraps at 2^ADDRESS_WIDTH with no error.
- in_start[c] while in RUN is ignored; in_base and in_length are not resampled.
- out_address and out_id are registered and hold their last values in IDLE. out_valid=0 in IDLE.
- out_busy[c] = (state==RUN).

## Timing
- Reset values, all channels: state IDLE, out_address=0, out_id=0, out_valid=0, out_busy=0, out_done=0, out_stall_count=0.
- Start sampled at edge t: busy=1 and the first beat is presented from cycle t+1 with address=in_base.
- Minimum burst time is length cycles when no stalls occur, one beat per cycle.
- Last beat accepted in cycle k: busy=0 and done=1 in cycle k+1; done=0 in k+2.
- A new start may be asserted in the done cycle (k+1); the burst then runs from k+2.
- Length-0 start at edge t: done=1 in cycle t+1, busy stays 0.
- Stall held indefinitely: the channel holds its state, address, id and remaining count.
- Reset asserted mid-burst: the burst is aborted, no done pulse is issued, and all reset values apply from the next cycle.
- Simultaneous start on all channels: all channels start in the same cycle; there is no arbitration.

## Configuration
- PRODUCER_STALL_CNT_EN defined:
  - Per-channel 16-bit counter increments each RUN cycle with in_stall[c]=1 and saturates at 0xFFFF.
  - It clears to 0 on an accepted start (including length 0) and holds its value in IDLE.
- PRODUCER_STALL_CNT_EN undefined: no counter logic is built; out_stall_count is tied to 0. The port is always present.

## Test plan
- Reset then single burst, channel 0: start base=0x100, length=3, no stall -> valid for 3 cycles with addresses 0x100/0x104/0x108, IDs 0/1/2; done 1 cycle after the last beat; busy low in that cycle.
- Stall mid-burst: length=4, stall held 2 cycles after the first beat -> exactly 4 beats with contiguous addresses; done 6 cycles after busy rises; stall_count=2 with macro, 0 without.
- Wrap: ADDRESS_WIDTH=8, ID_WIDTH=2, base=0xF8, length=6 -> addresses F8, FC, 00, 04, 08, 0C; IDs 0, 1, 2, 3, 0, 1.
- Length 0 and start-while-busy: length-0 start -> done next cycle, no valid; start pulse during RUN -> ignored, the original length completes.
- Independence, NUM_CH=4: all channels started together with differing lengths and stall patterns -> each channel's beats, IDs and done timing match a per-channel reference model.
- Reset mid-burst: reset asserted after the 2nd of 5 beats -> no done pulse; all outputs at reset values the next cycle; a subsequent burst starts at ID 0.
